io_channel_unit: RTL
====================

# io_channel_unit

Parametrised LED-command and capacitive-sensor I/O unit serving the processor execute stage. It replaces fixed nine-channel case decoding with an N-channel register bank behind a valid/ready request port. It adds a free-running sensor scanner that snapshots each channel in turn and keeps per-channel thresholds and sticky hit flags, so software polls hits instead of raw readings.

## Interface
- NUM_CH, 9, number of LED/sensor channels (1..32)
- LED_W, 16, bits per channel LED command
- SENS_W, 32, bits per sensor reading, threshold and response word (≥ NUM_CH, ≥ LED_W)
- CH_W, 4, channel index width (2^CH_W ≥ NUM_CH)

- clock  in  1  sole clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_op  in  2  00 LED write, 01 sensor read, 10 threshold write, 11 hit read-and-clear
- req_ch  in  CH_W  target channel
- req_wdata  in  SENS_W  write data (LED write uses [LED_W-1:0])
- rsp_valid  out  1  one-cycle response strobe
- rsp_data  out  SENS_W  response word
- rsp_err  out  1  request targeted channel ≥ NUM_CH
- scan_en  in  1  scanner advance enable
- sensor_readings  in  NUM_CH*SENS_W  raw readings, channel c at [c*SENS_W +: SENS_W]
- led_commands  out  NUM_CH*LED_W  registered LED commands, channel c at [c*LED_W +: LED_W]
- hit_flags  out  NUM_CH  sticky per-channel hit flags

## Operation
- Storage: led[NUM_CH], snapshot[NUM_CH], threshold[NUM_CH], hit[NUM_CH], scan_ptr, request FSM.
- Reset (async, reset_n low): led, snapshot, threshold, hit = 0. scan_ptr = 0. FSM = IDLE. rsp_valid, rsp_data, rsp_err = 0. An in-flight request is dropped with no response.
- FSM states:
  - IDLE: req_ready = 1. On req_valid, latch op, ch and wdata, then go to EXEC.
  - EXEC: req_ready = 0. On the next edge, perform the op, register the response, and go to IDLE.
- Ops, for a valid ch (< NUM_CH):
  - 00: led[ch] <= wdata[LED_W-1:0]; rsp_data = 0.
  - 01: rsp_data = snapshot[ch] as held before this edge.
  - 10: threshold[ch] <= wdata; rsp_data = 0.
  - 11: rsp_data = hit vector zero-extended to SENS_W, as held before this edge; hit[ch] cleared.
- Invalid ch (≥ NUM_CH): no state change; rsp_err = 1, rsp_data = 0. For valid ch, rsp_err = 0.
- Scanner:
  - Each edge with scan_en = 1: snapshot[scan_ptr] <= reading[scan_ptr].
  - Same edge: if threshold[scan_ptr] ≠ 0 and the unsigned reading ≥ threshold, set hit[scan_ptr].
  - scan_ptr increments and wraps from NUM_CH-1 to 0. scan_en = 0 freezes scan_ptr and the snapshots.
- Threshold 0 disables hit detection for that channel.
- Simultaneous events on the same edge:
  - Scanner set and op-11 clear of the same bit: set wins.
  - Scanner update and op-01 read of the same channel: the read returns the old snapshot.
  - Threshold write and compare on the same channel: the compare uses the old threshold.
- led_commands and hit_flags are direct register outputs.

## Timing
- Handshake at edge N (req_valid & req_ready). The effect and response are registered at edge N+1. rsp_valid is high for exactly the cycle after N+1.
- req_ready returns high in the same cycle rsp_valid is high. Maximum throughput is one request per 2 cycles.
- No response backpressure. rsp_data and rsp_err hold their values after rsp_valid drops, until the next response.
- An LED write is visible on led_commands the cycle after edge N+1.
- Sample-to-hit_flags latency is 1 cycle. Each channel is revisited every NUM_CH enabled cycles.

## Test plan
- Reset then idle: all outputs 0, req_ready = 1. Assert reset_n low during EXEC → no rsp_valid, FSM IDLE, led unchanged at 0.
- LED write op 00, ch 3, wdata 0xABCD_1234 → rsp_valid 2 cycles after accept, rsp_err 0; led_commands[63:48] = 0x1234, all other slices 0.
- Threshold write ch 2 = 500, scan_en = 1, channel 2 reading = 499 then 500 → hit_flags[2] stays 0 for 499 and rises after channel 2's scan slot with 500. Op 11 ch 2 → rsp_data = 0x4, then hit_flags[2] = 0.
- Op 11 on ch 5 issued on the same edge the scanner sets hit[5] → rsp_data bit 5 reflects the old value, hit_flags[5] = 1 afterwards.
- Op 01 ch 9 with NUM_CH = 9 → rsp_err = 1, rsp_data = 0, no register changes. Op 01 ch 8 after a full scan with reading 0x00C0FFEE → rsp_data = 0x00C0FFEE.
- Back-to-back: hold req_valid for 4 requests → accepted on alternate cycles, 4 rsp_valid pulses in order. scan_en low for 20 cycles → snapshots and scan_ptr unchanged.

Source files
------------

// File: rtl/io_channel_unit.sv
// N-channel LED command / sensor unit: register bank behind a valid/ready port plus a free-running threshold scanner.
// Accept-to-response 2 cycles; req_ready low while executing; responses are strobes with no backpressure.
module io_channel_unit #(
    parameter int NUM_CH = 9,
    parameter int LED_W  = 16,
    parameter int SENS_W = 32,
    parameter int CH_W   = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [CH_W-1:0]          req_ch,
    input  logic [SENS_W-1:0]        req_wdata,
    output logic                     rsp_valid,
    output logic [SENS_W-1:0]        rsp_data,
    output logic                     rsp_err,
    input  logic                     scan_en,
    input  logic [NUM_CH*SENS_W-1:0] sensor_readings,
    output logic [NUM_CH*LED_W-1:0]  led_commands,
    output logic [NUM_CH-1:0]        hit_flags
);
    typedef enum logic {IDLE, EXEC} state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [SENS_W-1:0]   wdata_q, wdata_d;
    logic [LED_W-1:0]    led_q   [NUM_CH];
    logic [LED_W-1:0]    led_d   [NUM_CH];
    logic [SENS_W-1:0]   snap_q  [NUM_CH];
    logic [SENS_W-1:0]   snap_d  [NUM_CH];
    logic [SENS_W-1:0]   thr_q   [NUM_CH];
    logic [SENS_W-1:0]   thr_d   [NUM_CH];
    logic [NUM_CH-1:0]   hit_q, hit_d;
    logic [CH_W-1:0]     scan_ptr_q, scan_ptr_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [SENS_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;

    logic [SENS_W-1:0]   reading [NUM_CH];
    logic [SENS_W-1:0]   cur_rd, cur_thr;
    logic                ch_ok;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign reading[c]                      = sensor_readings[c*SENS_W +: SENS_W];
        assign led_commands[c*LED_W +: LED_W]  = led_q[c];
    end

    assign ch_ok   = int'(ch_q) < NUM_CH;
    assign cur_rd  = reading[scan_ptr_q];
    assign cur_thr = thr_q[scan_ptr_q];

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ch_d        = ch_q;
        wdata_d     = wdata_q;
        led_d       = led_q;
        snap_d      = snap_q;
        thr_d       = thr_q;
        hit_d       = hit_q;
        scan_ptr_d  = scan_ptr_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    ch_d    = req_ch;
                    wdata_d = req_wdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_data_d  = '0;
                rsp_err_d   = !ch_ok;
                if (ch_ok) begin
                    case (op_q)
                        2'b00: led_d[ch_q] = wdata_q[LED_W-1:0];
                        2'b01: rsp_data_d  = snap_q[ch_q];
                        2'b10: thr_d[ch_q] = wdata_q;
                        2'b11: begin
                            rsp_data_d  = SENS_W'(hit_q);
                            hit_d[ch_q] = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase

        // Scanner runs after the op so a same-edge hit set overrides a read-and-clear.
        if (scan_en) begin
            snap_d[scan_ptr_q] = cur_rd;
            if (cur_thr != '0 && cur_rd >= cur_thr) begin
                hit_d[scan_ptr_q] = 1'b1;
            end
            scan_ptr_d = (scan_ptr_q == CH_W'(NUM_CH-1)) ? '0 : scan_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            ch_q        <= '0;
            wdata_q     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                led_q[i]  <= '0;
                snap_q[i] <= '0;
                thr_q[i]  <= '0;
            end
            hit_q       <= '0;
            scan_ptr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ch_q        <= ch_d;
            wdata_q     <= wdata_d;
            led_q       <= led_d;
            snap_q      <= snap_d;
            thr_q       <= thr_d;
            hit_q       <= hit_d;
            scan_ptr_q  <= scan_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign hit_flags = hit_q;

endmodule
